sp_tracker: RTL and testbench

SP_TRACKER -- requirements
Module: sp_tracker

---
 rtl/sp_tracker_if.sv | 37 +++
 rtl/sp_tracker.sv | 215 +++++++++++++++++++++
 tb/tb_sp_tracker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sp_tracker_if.sv
`timescale 1ns/1ps
// Control, sample and servo-command bundle between a sun-tracker controller
// and its environment.
interface sp_tracker_if #(
    parameter int unsigned VW = 10,
    parameter int unsigned PW = 4
);
    logic          start;
    logic          abort;
    logic          mode;
    logic [VW-1:0] v_in;

    logic [PW-1:0] pos_h;
    logic [PW-1:0] pos_v;
    logic          step_h;
    logic          step_v;
    logic          dir_h;
    logic          dir_v;
    logic [VW-1:0] max_v;
    logic [PW-1:0] best_h;
    logic [PW-1:0] best_v;
    logic [2:0]    stat;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, mode, v_in,
        input  pos_h, pos_v, step_h, step_v, dir_h, dir_v,
        input  max_v, best_h, best_v, stat, busy, done
    );

    modport slave (
        input  start, abort, mode, v_in,
        output pos_h, pos_v, step_h, step_v, dir_h, dir_v,
        output max_v, best_h, best_v, stat, busy, done
    );
endinterface

// File: rtl/sp_tracker.sv
`timescale 1ns/1ps
// Solar-panel sun tracker: sweeps the horizontal then vertical servo axis,
// captures the peak panel voltage and parks both axes at its position.
module sp_tracker #(
    parameter int unsigned VW         = 10,
    parameter int unsigned H_STEPS    = 16,
    parameter int unsigned V_STEPS    = 8,
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned REST_TICKS = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_tracker_if.slave bus
);
    localparam int unsigned MAX_STEPS = (H_STEPS > V_STEPS) ? H_STEPS : V_STEPS;
    localparam int unsigned PW = ($clog2(MAX_STEPS) > 1) ? $clog2(MAX_STEPS) : 1;
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned RW = (REST_TICKS > 1) ? $clog2(REST_TICKS) : 1;

    localparam logic [PW-1:0] H_LAST   = PW'(H_STEPS - 1);
    localparam logic [PW-1:0] V_LAST   = PW'(V_STEPS - 1);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REST_MAX = RW'(REST_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_H_SWEEP  = 3'd1,
        S_H_RETURN = 3'd2,
        S_V_SWEEP  = 3'd3,
        S_V_RETURN = 3'd4,
        S_DONE     = 3'd5,
        S_REST     = 3'd6
    } state_e;

    state_e        state;
    logic [TW-1:0] presc;
    logic [RW-1:0] rest_cnt;
    logic          mode_q;
    logic [PW-1:0] pos_h;
    logic [PW-1:0] pos_v;
    logic [PW-1:0] best_h;
    logic [PW-1:0] best_v;
    logic [VW-1:0] max_v;
    logic          step_h;
    logic          step_v;
    logic          dir_h;
    logic          dir_v;
    logic          busy;
    logic          done;

    logic tick;
    logic hit;
    logic home;

    assign tick = (presc == TICK_MAX);
    assign hit  = (bus.v_in > max_v);

    // A new cycle starts from IDLE on START, or from REST after the last rest tick.
    assign home = !bus.abort &&
                  (((state == S_IDLE) && bus.start) ||
                   ((state == S_REST) && tick && (rest_cnt == REST_MAX)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            presc    <= '0;
            rest_cnt <= '0;
            mode_q   <= 1'b0;
            pos_h    <= '0;
            pos_v    <= '0;
            best_h   <= '0;
            best_v   <= '0;
            max_v    <= '0;
            step_h   <= 1'b0;
            step_v   <= 1'b0;
            dir_h    <= 1'b0;
            dir_v    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            step_h <= 1'b0;
            step_v <= 1'b0;
            done   <= 1'b0;

            // Held at zero through DONE so REST spans exactly REST_TICKS full tick periods.
            if ((state == S_IDLE) || (state == S_DONE) || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end

            if (bus.abort) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                rest_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.start) begin
                            state <= S_H_SWEEP;
                            busy  <= 1'b1;
                        end
                    end
                    S_H_SWEEP: begin
                        if (tick) begin
                            if (hit) begin
                                max_v  <= bus.v_in;
                                best_h <= pos_h;
                            end
                            if (pos_h == H_LAST) begin
                                state <= S_H_RETURN;
                            end else begin
                                pos_h  <= pos_h + 1'b1;
                                step_h <= 1'b1;
                                dir_h  <= 1'b1;
                            end
                        end
                    end
                    S_H_RETURN: begin
                        if (tick) begin
                            if (pos_h > best_h) begin
                                pos_h  <= pos_h - 1'b1;
                                step_h <= 1'b1;
                                dir_h  <= 1'b0;
                            end else begin
                                state <= S_V_SWEEP;
                            end
                        end
                    end
                    S_V_SWEEP: begin
                        if (tick) begin
                            if (hit) begin
                                max_v  <= bus.v_in;
                                best_v <= pos_v;
                            end
                            if (pos_v == V_LAST) begin
                                state <= S_V_RETURN;
                            end else begin
                                pos_v  <= pos_v + 1'b1;
                                step_v <= 1'b1;
                                dir_v  <= 1'b1;
                            end
                        end
                    end
                    S_V_RETURN: begin
                        if (tick) begin
                            if (pos_v > best_v) begin
                                pos_v  <= pos_v - 1'b1;
                                step_v <= 1'b1;
                                dir_v  <= 1'b0;
                            end else begin
                                state  <= S_DONE;
                                done   <= 1'b1;
                                mode_q <= bus.mode;
                            end
                        end
                    end
                    S_DONE: begin
                        if (mode_q) begin
                            state    <= S_REST;
                            rest_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    S_REST: begin
                        if (tick) begin
                            if (rest_cnt == REST_MAX) begin
                                state    <= S_H_SWEEP;
                                rest_cnt <= '0;
                            end else begin
                                rest_cnt <= rest_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            // Homing clears the capture and steps only axes that actually move.
            if (home) begin
                pos_h  <= '0;
                pos_v  <= '0;
                max_v  <= '0;
                best_h <= '0;
                best_v <= '0;
                if (pos_h != '0) begin
                    step_h <= 1'b1;
                    dir_h  <= 1'b0;
                end
                if (pos_v != '0) begin
                    step_v <= 1'b1;
                    dir_v  <= 1'b0;
                end
            end
        end
    end

    assign bus.pos_h  = pos_h;
    assign bus.pos_v  = pos_v;
    assign bus.step_h = step_h;
    assign bus.step_v = step_v;
    assign bus.dir_h  = dir_h;
    assign bus.dir_v  = dir_v;
    assign bus.max_v  = max_v;
    assign bus.best_h = best_h;
    assign bus.best_v = best_v;
    assign bus.stat   = state;
    assign bus.busy   = busy;
    assign bus.done   = done;
endmodule

// File: tb/tb_sp_tracker.sv
`timescale 1ns/1ps
// Bench for sp_tracker: fixed-profile vector table, hand sequences for
// abort/auto-repeat/reset, and random profiles against a sweep model.
module tb_sp_tracker;
    localparam int unsigned VW = 10;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned TD = 2;
    localparam int unsigned RT = 3;
    localparam int unsigned PW = 3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   prof [H][V];

    sp_tracker_if #(.VW(VW), .PW(PW)) bus ();

    sp_tracker #(
        .VW(VW), .H_STEPS(H), .V_STEPS(V), .TICK_DIV(TD), .REST_TICKS(RT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int e_max;
        int e_bh;
        int e_bv;
        int e_cyc;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void fill_prof(input int kind);
        for (int h = 0; h < H; h++) begin
            for (int v = 0; v < V; v++) begin
                case (kind)
                    0:       prof[h][v] = 200;
                    1:       prof[h][v] = (h <= 5) ? (100 + 10 * h) : (150 - 20 * (h - 5));
                    2:       prof[h][v] = (v == 2) ? 300 : 100;
                    default: prof[h][v] = 50 * h + 10 * v;
                endcase
            end
        end
    endfunction

    // Peak search as the sweep rules describe it: H row at v=0, then column at best h.
    task automatic model(output int m, output int bh, output int bv);
        m = 0; bh = 0; bv = 0;
        for (int h = 0; h < H; h++) begin
            if (prof[h][0] > m) begin m = prof[h][0]; bh = h; end
        end
        for (int v = 0; v < V; v++) begin
            if (prof[bh][v] > m) begin m = prof[bh][v]; bv = v; end
        end
    endtask

    task automatic sweep(input string nm, input logic md, input int e_cyc,
                         input int e_max, input int e_bh, input int e_bv);
        int cyc = 0;
        int uh = 0, dh = 0, uv = 0, dv = 0;
        bit seen = 1'b0;
        bus.mode  = md;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({nm, "_busy"}, int'(bus.busy), 1);
        while (!seen && cyc < 400) begin
            bus.v_in = VW'(prof[bus.pos_h][bus.pos_v]);
            @(posedge clk); #1;
            cyc++;
            if (bus.step_h) begin if (bus.dir_h) uh++; else dh++; end
            if (bus.step_v) begin if (bus.dir_v) uv++; else dv++; end
            seen = bus.done;
        end
        chk({nm, "_done_seen"}, int'(seen), 1);
        chk({nm, "_cycles"}, cyc, e_cyc);
        chk({nm, "_max_v"}, int'(bus.max_v), e_max);
        chk({nm, "_best_h"}, int'(bus.best_h), e_bh);
        chk({nm, "_best_v"}, int'(bus.best_v), e_bv);
        chk({nm, "_pos_h"}, int'(bus.pos_h), e_bh);
        chk({nm, "_pos_v"}, int'(bus.pos_v), e_bv);
        chk({nm, "_up_h"}, uh, H - 1);
        chk({nm, "_down_h"}, dh, H - 1 - e_bh);
        chk({nm, "_up_v"}, uv, V - 1);
        chk({nm, "_down_v"}, dv, V - 1 - e_bv);
        chk({nm, "_stat_done"}, int'(bus.stat), 5);
    endtask

    task automatic idle_after(input string nm);
        @(posedge clk); #1;
        chk({nm, "_idle_stat"}, int'(bus.stat), 0);
        chk({nm, "_idle_busy"}, int'(bus.busy), 0);
        chk({nm, "_idle_done"}, int'(bus.done), 0);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_pos_h"}, int'(bus.pos_h), 0);
        chk({nm, "_pos_v"}, int'(bus.pos_v), 0);
        chk({nm, "_max_v"}, int'(bus.max_v), 0);
        chk({nm, "_best_h"}, int'(bus.best_h), 0);
        chk({nm, "_best_v"}, int'(bus.best_v), 0);
        chk({nm, "_steps"}, int'({bus.step_h, bus.step_v}), 0);
        chk({nm, "_dirs"}, int'({bus.dir_h, bus.dir_v}), 0);
        chk({nm, "_done"}, int'(bus.done), 0);
        chk({nm, "_busy"}, int'(bus.busy), 0);
        chk({nm, "_stat"}, int'(bus.stat), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        int n;
        int m, bh, bv;

        vecs[0] = '{kind: 0, e_max: 200, e_bh: 0, e_bv: 0, e_cyc: 48};
        vecs[1] = '{kind: 1, e_max: 150, e_bh: 5, e_bv: 0, e_cyc: 38};
        vecs[2] = '{kind: 2, e_max: 300, e_bh: 0, e_bv: 2, e_cyc: 44};
        vecs[3] = '{kind: 3, e_max: 380, e_bh: 7, e_bv: 3, e_cyc: 28};

        total = 0;
        bad   = 0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mode  = 1'b0;
        bus.v_in  = '0;
        rst_n     = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check_zero("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", int'(bus.stat), 0);

        for (int i = 0; i < 4; i++) begin
            fill_prof(vecs[i].kind);
            sweep($sformatf("vec%0d", i), 1'b0, vecs[i].e_cyc,
                  vecs[i].e_max, vecs[i].e_bh, vecs[i].e_bv);
            idle_after($sformatf("vec%0d", i));
        end

        // Abort mid horizontal sweep, START while busy, ABORT+START together, rehome.
        fill_prof(0);
        bus.v_in  = VW'(200);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("home_step_h", int'(bus.step_h), 1);
        chk("home_dir_h", int'(bus.dir_h), 0);
        n = 0;
        while (bus.pos_h != 3'd2 && n < 100) begin @(posedge clk); #1; n++; end
        chk("abort_reach2", int'(bus.pos_h), 2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_start_stat", int'(bus.stat), 1);
        chk("busy_start_pos", int'(bus.pos_h >= 3'd2), 1);
        n = 0;
        while (bus.pos_h != 3'd3 && n < 100) begin @(posedge clk); #1; n++; end
        chk("abort_reach3", int'(bus.pos_h), 3);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        chk("abort_stat", int'(bus.stat), 0);
        chk("abort_pos_h", int'(bus.pos_h), 3);
        chk("abort_max_v", int'(bus.max_v), 200);
        chk("abort_step_h", int'(bus.step_h), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_busy", int'(bus.busy), 0);
        bus.abort = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("abort_start_stat", int'(bus.stat), 0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("rehome_stat", int'(bus.stat), 1);
        chk("rehome_pos_h", int'(bus.pos_h), 0);
        chk("rehome_step_h", int'(bus.step_h), 1);
        chk("rehome_max_v", int'(bus.max_v), 0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;

        // Auto-repeat: DONE, REST for RT ticks, then a fresh sweep with cleared capture.
        fill_prof(0);
        sweep("auto", 1'b1, 48, 200, 0, 0);
        @(posedge clk); #1;
        chk("auto_rest_stat", int'(bus.stat), 6);
        chk("auto_rest_busy", int'(bus.busy), 1);
        n = 1;
        while (bus.stat == 3'd6 && n < 20) begin @(posedge clk); #1; n++; end
        chk("auto_rest_cycles", n - 1, RT * TD);
        chk("auto_resweep_stat", int'(bus.stat), 1);
        chk("auto_resweep_max", int'(bus.max_v), 0);
        bus.mode  = 1'b0;
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;

        for (int r = 0; r < 8; r++) begin
            for (int h = 0; h < H; h++) begin
                for (int v = 0; v < V; v++) prof[h][v] = int'($urandom_range(0, 6)) * 150;
            end
            model(m, bh, bv);
            sweep($sformatf("rnd%0d", r), 1'b0, 2 * (2 * H + 2 * V - bh - bv), m, bh, bv);
            idle_after($sformatf("rnd%0d", r));
        end

        // Reset asserted during V_RETURN, away from any clock edge.
        fill_prof(0);
        bus.v_in  = VW'(200);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (bus.stat != 3'd4 && n < 200) begin @(posedge clk); #1; n++; end
        chk("rst_reach_vret", int'(bus.stat), 4);
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ignored", int'(bus.stat), 0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_idle", int'(bus.stat), 0);
        chk("rst_release_done", int'(bus.done), 0);
        fill_prof(1);
        sweep("post_rst", 1'b0, 38, 150, 5, 0);
        idle_after("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
